// File: rtl/strat_pkg.sv
// Shared strategy-path definitions: FSM state type, side encoding and
// default widths used by order_gate and its risk check.
package strat_pkg;

  localparam int DEF_W        = 32;
  localparam int DEF_QTY_W    = 16;
  localparam int DEF_POS_W    = 24;
  localparam int DEF_COOLDOWN = 8;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    COOL
  } gate_state_t;

endpackage

// File: rtl/order_gate_risk.sv
// Combinational position-limit check for a candidate order.
// Arithmetic is carried one bit wider than the position so that the
// candidate position can never wrap before it is compared to the bound.
module order_gate_risk
  import strat_pkg::*;
#(
  parameter int QTY_W = DEF_QTY_W,
  parameter int POS_W = DEF_POS_W
) (
  input  logic signed [POS_W-1:0] position,
  input  logic                    side,
  input  logic [QTY_W-1:0]        order_qty,
  input  logic [POS_W-2:0]        pos_limit,
  output logic                    pass
);

  logic signed [POS_W:0] pos_ext;
  logic signed [POS_W:0] qty_ext;
  logic signed [POS_W:0] lim_ext;

  assign pos_ext = {position[POS_W-1], position};
  assign qty_ext = signed'((POS_W+1)'(order_qty));
  assign lim_ext = {2'b00, pos_limit};

  // Buy must stay at or below +limit, sell at or above -limit.
  always_comb begin
    pass = 1'b0;
    if (side == SIDE_BUY) begin
      pass = (pos_ext + qty_ext) <= lim_ext;
    end else begin
      pass = (pos_ext - qty_ext) >= -lim_ext;
    end
  end

endmodule

// File: rtl/order_gate.sv
// Order gate: turns strategy buy/sell decisions into single downstream
// orders, enforcing a position limit, a valid/ready handshake and a
// post-order cooldown. Define ORDER_GATE_STATS_EN to build the saturating
// drop counter; without it drop_cnt reads as zero and no counter exists.
module order_gate
  import strat_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int QTY_W    = DEF_QTY_W,
  parameter int POS_W    = DEF_POS_W,
  parameter int COOLDOWN = DEF_COOLDOWN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    buy,
  input  logic                    sell,
  input  logic [W-1:0]            bid_px0,
  input  logic [W-1:0]            ask_px0,
  input  logic [QTY_W-1:0]        order_qty,
  input  logic [POS_W-2:0]        pos_limit,
  input  logic                    enable,
  output logic                    ord_valid,
  input  logic                    ord_ready,
  output logic                    ord_side,
  output logic [W-1:0]            ord_px,
  output logic [QTY_W-1:0]        ord_qty,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic [15:0]             drop_cnt
);

  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] COOL_LOAD =
    (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;

  gate_state_t             state;
  logic [CNT_W-1:0]        cool_cnt;
  logic                    risk_pass;
  logic                    accept;
  logic signed [POS_W-1:0] qty_pos;

  order_gate_risk #(
    .QTY_W (QTY_W),
    .POS_W (POS_W)
  ) u_risk (
    .position  (position),
    .side      (buy),
    .order_qty (order_qty),
    .pos_limit (pos_limit),
    .pass      (risk_pass)
  );

  // A decision is taken only when idle, armed, unambiguous and within limits.
  assign accept  = in_valid && enable && (buy ^ sell) && risk_pass && (state == IDLE);
  assign qty_pos = signed'(POS_W'(ord_qty));
  assign busy    = (state != IDLE);

  // Main FSM: latch the order, hold it until accepted, then cool down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ord_valid <= 1'b0;
      ord_side  <= SIDE_SELL;
      ord_px    <= '0;
      ord_qty   <= '0;
      position  <= '0;
      cool_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ord_side  <= buy ? SIDE_BUY : SIDE_SELL;
            ord_px    <= buy ? ask_px0 : bid_px0;
            ord_qty   <= order_qty;
            ord_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (ord_ready) begin
            ord_valid <= 1'b0;
            position  <= (ord_side == SIDE_BUY) ? position + qty_pos
                                                : position - qty_pos;
            if (COOLDOWN > 0) begin
              state    <= COOL;
              cool_cnt <= COOL_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        COOL: begin
          if (cool_cnt == '0) begin
            state <= IDLE;
          end else begin
            cool_cnt <= cool_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ord_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ORDER_GATE_STATS_EN
  logic        drop_evt;
  logic [15:0] drop_q;

  // Any real decision that does not become an order is a drop.
  assign drop_evt = in_valid && (buy || sell) && !accept;
  assign drop_cnt = drop_q;

  // Saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_evt && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_order_gate.sv
// Directed bench for order_gate: one instance with the default cooldown of 8
// and one with no cooldown, driven by a shared linear stimulus sequence.
module tb_order_gate;

`ifdef ORDER_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        buy;
  logic        sell;
  logic [31:0] bid_px0;
  logic [31:0] ask_px0;
  logic [15:0] order_qty;
  logic [22:0] pos_limit;
  logic        enable;
  logic        ord_ready;

  logic               ord_valid, ord_side, busy;
  logic [31:0]        ord_px;
  logic [15:0]        ord_qty, drop_cnt;
  logic signed [23:0] position;

  logic               ord_valid0, ord_side0, busy0;
  logic [31:0]        ord_px0;
  logic [15:0]        ord_qty0, drop_cnt0;
  logic signed [23:0] position0;

  int checks;
  int errors;

  order_gate #(.W(32), .QTY_W(16), .POS_W(24), .COOLDOWN(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .buy(buy), .sell(sell),
    .bid_px0(bid_px0), .ask_px0(ask_px0), .order_qty(order_qty),
    .pos_limit(pos_limit), .enable(enable), .ord_valid(ord_valid),
    .ord_ready(ord_ready), .ord_side(ord_side), .ord_px(ord_px),
    .ord_qty(ord_qty), .position(position), .busy(busy), .drop_cnt(drop_cnt)
  );

  order_gate #(.W(32), .QTY_W(16), .POS_W(24), .COOLDOWN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .buy(buy), .sell(sell),
    .bid_px0(bid_px0), .ask_px0(ask_px0), .order_qty(order_qty),
    .pos_limit(pos_limit), .enable(enable), .ord_valid(ord_valid0),
    .ord_ready(ord_ready), .ord_side(ord_side0), .ord_px(ord_px0),
    .ord_qty(ord_qty0), .position(position0), .busy(busy0), .drop_cnt(drop_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] expDrop(input int n);
    return STATS ? 64'(n) : 64'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic b, input logic s);
    in_valid = iv;
    buy      = b;
    sell     = s;
    step();
    in_valid = 1'b0;
    buy      = 1'b0;
    sell     = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    checkOutput(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    buy       = 1'b0;
    sell      = 1'b0;
    enable    = 1'b0;
    pos_limit = 23'd100;
    order_qty = 16'd10;
    ask_px0   = 32'd1000;
    bid_px0   = 32'd990;
    ord_ready = 1'b1;

    #2;
    checkOutput("rst_valid", 64'(ord_valid), 64'd0);
    checkOutput("rst_pos",   64'(position),  64'd0);
    checkOutput("rst_busy",  64'(busy),      64'd0);
    checkOutput("rst_drop",  64'(drop_cnt),  64'd0);
    checkOutput("rst_px",    64'(ord_px),    64'd0);

    step();
    step();
    rst    = 1'b0;
    enable = 1'b1;

    // Basic buy, then exactly 1 + 8 busy cycles
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("buy_valid", 64'(ord_valid), 64'd1);
    checkOutput("buy_side",  64'(ord_side),  64'd1);
    checkOutput("buy_px",    64'(ord_px),    64'd1000);
    checkOutput("buy_qty",   64'(ord_qty),   64'd10);
    checkOutput("buy_busy",  64'(busy),      64'd1);
    checkOutput("buy_pos0",  64'(position),  64'd0);
    step();
    checkOutput("hs_valid", 64'(ord_valid), 64'd0);
    checkOutput("hs_pos",   64'(position),  64'd10);
    checkOutput("hs_busy",  64'(busy),      64'd1);
    repeat (7) step();
    checkOutput("cool_last_busy", 64'(busy), 64'd1);
    step();
    checkOutput("cool_done_busy", 64'(busy), 64'd0);

    // Conflicting decision, empty decision, disarmed decision
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("both_valid", 64'(ord_valid), 64'd0);
    checkOutput("both_busy",  64'(busy),      64'd0);
    checkOutput("both_drop",  64'(drop_cnt),  expDrop(1));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("none_valid", 64'(ord_valid), 64'd0);
    checkOutput("none_drop",  64'(drop_cnt),  expDrop(1));
    enable = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    enable = 1'b1;
    checkOutput("dis_valid", 64'(ord_valid), 64'd0);
    checkOutput("dis_drop",  64'(drop_cnt),  expDrop(2));

    // Build position to 95, then risk-fail a buy and pass a sell
    order_qty = 16'd85;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("big_qty", 64'(ord_qty), 64'd85);
    step();
    checkOutput("pos95", 64'(position), 64'd95);
    waitIdle("idle_a");
    order_qty = 16'd10;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("risk_valid", 64'(ord_valid), 64'd0);
    checkOutput("risk_drop",  64'(drop_cnt),  expDrop(3));
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("sell_valid", 64'(ord_valid), 64'd1);
    checkOutput("sell_side",  64'(ord_side),  64'd0);
    checkOutput("sell_px",    64'(ord_px),    64'd990);
    step();
    checkOutput("pos85", 64'(position), 64'd85);
    waitIdle("idle_b");

    // Buy landing exactly on the limit is allowed
    order_qty = 16'd15;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("edge_valid", 64'(ord_valid), 64'd1);
    step();
    checkOutput("pos100", 64'(position), 64'd100);
    waitIdle("idle_c");

    // Backpressure for 5 cycles with a stray decision and enable dropping
    order_qty = 16'd10;
    bid_px0   = 32'd980;
    ord_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("bp_valid", 64'(ord_valid), 64'd1);
    checkOutput("bp_px",    64'(ord_px),    64'd980);
    bid_px0 = 32'd970;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bp1_valid", 64'(ord_valid), 64'd1);
    checkOutput("bp1_px",    64'(ord_px),    64'd980);
    checkOutput("bp1_pos",   64'(position),  64'd100);
    checkOutput("bp1_drop",  64'(drop_cnt),  expDrop(4));
    enable = 1'b0;
    step();
    checkOutput("bp2_valid", 64'(ord_valid), 64'd1);
    checkOutput("bp2_side",  64'(ord_side),  64'd0);
    checkOutput("bp2_pos",   64'(position),  64'd100);
    step();
    checkOutput("bp3_valid", 64'(ord_valid), 64'd1);
    checkOutput("bp3_qty",   64'(ord_qty),   64'd10);
    enable = 1'b1;
    step();
    checkOutput("bp4_valid", 64'(ord_valid), 64'd1);
    step();
    checkOutput("bp5_valid", 64'(ord_valid), 64'd1);
    checkOutput("bp5_px",    64'(ord_px),    64'd980);
    checkOutput("bp5_pos",   64'(position),  64'd100);
    ord_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bphs_valid", 64'(ord_valid), 64'd0);
    checkOutput("bphs_pos",   64'(position),  64'd90);
    checkOutput("bphs_drop",  64'(drop_cnt),  expDrop(5));
    checkOutput("bphs_busy",  64'(busy),      64'd1);
    waitIdle("idle_d");

    // Reset in the middle of an offer
    ord_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("mr_valid", 64'(ord_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 64'(ord_valid), 64'd0);
    checkOutput("ar_pos",   64'(position),  64'd0);
    checkOutput("ar_busy",  64'(busy),      64'd0);
    checkOutput("ar_px",    64'(ord_px),    64'd0);
    checkOutput("ar_qty",   64'(ord_qty),   64'd0);
    checkOutput("ar_side",  64'(ord_side),  64'd0);
    checkOutput("ar_drop",  64'(drop_cnt),  64'd0);
    checkOutput("ar_pos0",  64'(position0), 64'd0);
    step();
    rst       = 1'b0;
    ord_ready = 1'b1;

    // Back-to-back decisions: zero-cooldown gate re-accepts right after handshake
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("b2b0_valid",  64'(ord_valid0), 64'd1);
    checkOutput("b2b8_valid",  64'(ord_valid),  64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("b2b1_valid0", 64'(ord_valid0), 64'd0);
    checkOutput("b2b1_pos0",   64'(position0),  64'd10);
    checkOutput("b2b1_pos8",   64'(position),   64'd10);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("b2b2_valid0", 64'(ord_valid0), 64'd1);
    checkOutput("b2b2_side0",  64'(ord_side0),  64'd1);
    checkOutput("b2b2_px0",    64'(ord_px0),    64'd1000);
    checkOutput("b2b2_qty0",   64'(ord_qty0),   64'd10);
    checkOutput("b2b2_valid8", 64'(ord_valid),  64'd0);
    checkOutput("b2b2_busy8",  64'(busy),       64'd1);
    step();
    checkOutput("b2b3_pos0",   64'(position0),  64'd20);
    checkOutput("b2b3_valid0", 64'(ord_valid0), 64'd0);
    checkOutput("b2b3_busy0",  64'(busy0),      64'd0);
    checkOutput("b2b3_drop0",  64'(drop_cnt0),  expDrop(1));
    checkOutput("b2b3_drop8",  64'(drop_cnt),   expDrop(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
